// File: rtl/arch_defs_pkg.sv
// rtl/arch_defs_pkg.sv - shared state encoding and stream constants for ram_dumper
package arch_defs_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        HDR,
        READ,
        CAPT,
        SEND,
        SUM,
        DONE
    } dump_state_t;

    localparam logic [7:0] DUMP_HDR = 8'hA5;

    // The RAM port stays claimed from the request until the checksum has gone out.
    function automatic logic holds_bus(input dump_state_t s);
        return (s == REQ) || (s == HDR) || (s == READ) ||
               (s == CAPT) || (s == SEND) || (s == SUM);
    endfunction

    function automatic logic presents_byte(input dump_state_t s);
        return (s == HDR) || (s == SEND) || (s == SUM);
    endfunction

endpackage

// File: rtl/ram_dumper_if.sv
// rtl/ram_dumper_if.sv - RAM port arbitration, RAM read and byte stream signals of ram_dumper
interface ram_dumper_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
);
    logic                  bus_req;
    logic                  bus_grant;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic                  ram_rd_en;
    logic [DATA_WIDTH-1:0] ram_rdata;
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_valid;
    logic                  tx_ready;

    modport master (
        output bus_req,
        output ram_addr,
        output ram_rd_en,
        output tx_data,
        output tx_valid,
        input  bus_grant,
        input  ram_rdata,
        input  tx_ready
    );

    modport slave (
        input  bus_req,
        input  ram_addr,
        input  ram_rd_en,
        input  tx_data,
        input  tx_valid,
        output bus_grant,
        output ram_rdata,
        output tx_ready
    );

endinterface

// File: rtl/ram_dumper.sv
// rtl/ram_dumper.sv - dumps a wrapping RAM address range as header, data bytes and mod-256 checksum
module ram_dumper
    import arch_defs_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] first_addr,
    input  logic [ADDR_WIDTH-1:0] last_addr,
    output logic                  busy,
    output logic                  done,
    ram_dumper_if.master          bus
);

    dump_state_t           state;
    dump_state_t           state_next;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] last_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [DATA_WIDTH-1:0] checksum_q;
    logic                  at_last;

    assign at_last = (addr_q == last_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start)         state_next = REQ;
            REQ:     if (bus.bus_grant) state_next = HDR;
            HDR:     if (bus.tx_ready)  state_next = READ;
            READ:    if (bus.bus_grant) state_next = CAPT;
            CAPT:                       state_next = SEND;
            SEND:    if (bus.tx_ready)  state_next = at_last ? SUM : READ;
            SUM:     if (bus.tx_ready)  state_next = DONE;
            DONE:                       state_next = IDLE;
            default:                    state_next = IDLE;
        endcase
    end

    // Address walks with natural ADDR_WIDTH wrap, so last < first dumps across the top of RAM.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q     <= '0;
            last_q     <= '0;
            data_q     <= '0;
            checksum_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        addr_q     <= first_addr;
                        last_q     <= last_addr;
                        checksum_q <= '0;
                    end
                end
                CAPT: begin
                    data_q     <= bus.ram_rdata;
                    checksum_q <= checksum_q + bus.ram_rdata;
                end
                SEND: begin
                    if (bus.tx_ready && !at_last) begin
                        addr_q <= addr_q + ADDR_WIDTH'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        busy          = (state != IDLE);
        done          = (state == DONE);
        bus.bus_req   = holds_bus(state);
        bus.ram_rd_en = (state == READ) && bus.bus_grant;
        bus.ram_addr  = addr_q;
        bus.tx_valid  = presents_byte(state);
        case (state)
            HDR:     bus.tx_data = DATA_WIDTH'(DUMP_HDR);
            SEND:    bus.tx_data = data_q;
            SUM:     bus.tx_data = checksum_q;
            default: bus.tx_data = '0;
        endcase
    end

endmodule
